// File: rtl/riscv_single_pkg.sv
// Shared encodings for the single-cycle RV32I core: opcodes, ALU control,
// immediate formats and write-back sources.
package riscv_single_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_PASSB
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J,
        IMM_U
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU,
        RES_MEM,
        RES_PC4
    } result_src_e;

endpackage

// File: rtl/riscv_single_decoder.sv
// Instruction decoder: maps opcode/funct fields to datapath controls.
// lui is decoded only when RISCV_SINGLE_LUI_EN is defined.
module riscv_single_decoder
    import riscv_single_pkg::*;
(
    input  logic [31:0] Instr,
    output logic        RegWrite,
    output imm_src_e    ImmSrc,
    output logic        ALUSrc,
    output alu_ctrl_e   ALUControl,
    output logic        MemWrite,
    output result_src_e ResultSrc,
    output logic        Branch,
    output logic        Jump
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode        = Instr[6:0];
    assign funct3        = Instr[14:12];
    assign funct7        = Instr[31:25];
    assign unused_fields = ^Instr[24:7];

    // Anything not matched falls through to the all-zero defaults, which is
    // a no-op that simply advances PC by 4.
    always_comb begin
        RegWrite   = 1'b0;
        ImmSrc     = IMM_I;
        ALUSrc     = 1'b0;
        ALUControl = ALU_ADD;
        MemWrite   = 1'b0;
        ResultSrc  = RES_ALU;
        Branch     = 1'b0;
        Jump       = 1'b0;
        case (opcode)
            OP_LOAD: begin
                if (funct3 == F3_LW) begin
                    RegWrite  = 1'b1;
                    ALUSrc    = 1'b1;
                    ResultSrc = RES_MEM;
                end
            end
            OP_STORE: begin
                if (funct3 == F3_SW) begin
                    MemWrite = 1'b1;
                    ALUSrc   = 1'b1;
                    ImmSrc   = IMM_S;
                end
            end
            OP_RTYPE: begin
                if (funct7 == F7_BASE) begin
                    RegWrite = 1'b1;
                    case (funct3)
                        F3_ADD:  ALUControl = ALU_ADD;
                        F3_SLT:  ALUControl = ALU_SLT;
                        F3_OR:   ALUControl = ALU_OR;
                        F3_AND:  ALUControl = ALU_AND;
                        default: RegWrite   = 1'b0;
                    endcase
                end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
                    RegWrite   = 1'b1;
                    ALUControl = ALU_SUB;
                end
            end
            OP_ITYPE: begin
                ALUSrc   = 1'b1;
                RegWrite = 1'b1;
                case (funct3)
                    F3_ADD:  ALUControl = ALU_ADD;
                    F3_SLT:  ALUControl = ALU_SLT;
                    F3_OR:   ALUControl = ALU_OR;
                    F3_AND:  ALUControl = ALU_AND;
                    default: RegWrite   = 1'b0;
                endcase
            end
            OP_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    Branch     = 1'b1;
                    ImmSrc     = IMM_B;
                    ALUControl = ALU_SUB;
                end
            end
            OP_JAL: begin
                Jump      = 1'b1;
                RegWrite  = 1'b1;
                ImmSrc    = IMM_J;
                ResultSrc = RES_PC4;
            end
`ifdef RISCV_SINGLE_LUI_EN
            OP_LUI: begin
                RegWrite   = 1'b1;
                ALUSrc     = 1'b1;
                ImmSrc     = IMM_U;
                ALUControl = ALU_PASSB;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_single.sv
// Single-cycle RV32I subset core (lw/sw/R-ALU/I-ALU/beq/jal); optional lui
// enabled by defining RISCV_SINGLE_LUI_EN.
module riscv_single
    import riscv_single_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] PC,
    input  logic [31:0] Instr,
    output logic        MemWrite,
    output logic [31:0] DataAdr,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    logic        reg_write;
    logic        alu_src;
    logic        mem_write;
    logic        branch;
    logic        jump;
    imm_src_e    imm_src;
    alu_ctrl_e   alu_ctrl;
    result_src_e result_src;

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] pc_target;
    logic [31:0] rf_reg [32];
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic [31:0] result;
    logic        zero;
    logic        rf_we;
    logic        unused_opcode;

    riscv_single_decoder u_decoder (
        .Instr      (Instr),
        .RegWrite   (reg_write),
        .ImmSrc     (imm_src),
        .ALUSrc     (alu_src),
        .ALUControl (alu_ctrl),
        .MemWrite   (mem_write),
        .ResultSrc  (result_src),
        .Branch     (branch),
        .Jump       (jump)
    );

    assign rs1           = Instr[19:15];
    assign rs2           = Instr[24:20];
    assign rd            = Instr[11:7];
    assign unused_opcode = ^Instr[6:0];

    // x0 is hard-wired at the read port; its storage is never written.
    assign rd1 = (rs1 == 5'd0) ? 32'd0 : rf_reg[rs1];
    assign rd2 = (rs2 == 5'd0) ? 32'd0 : rf_reg[rs2];

    always_comb begin
        imm_ext = {{20{Instr[31]}}, Instr[31:20]};
        case (imm_src)
            IMM_I: imm_ext = {{20{Instr[31]}}, Instr[31:20]};
            IMM_S: imm_ext = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
            IMM_B: imm_ext = {{20{Instr[31]}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
            IMM_J: imm_ext = {{12{Instr[31]}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};
            IMM_U: imm_ext = {Instr[31:12], 12'h000};
            default: ;
        endcase
    end

    assign src_b = alu_src ? imm_ext : rd2;

    always_comb begin
        alu_result = rd1 + src_b;
        case (alu_ctrl)
            ALU_ADD:   alu_result = rd1 + src_b;
            ALU_SUB:   alu_result = rd1 - src_b;
            ALU_AND:   alu_result = rd1 & src_b;
            ALU_OR:    alu_result = rd1 | src_b;
            ALU_SLT:   alu_result = {31'd0, $signed(rd1) < $signed(src_b)};
            ALU_PASSB: alu_result = src_b;
            default: ;
        endcase
    end

    assign zero = (alu_result == 32'd0);

    always_comb begin
        result = alu_result;
        case (result_src)
            RES_ALU: result = alu_result;
            RES_MEM: result = ReadData;
            RES_PC4: result = pc_plus4;
            default: ;
        endcase
    end

    assign pc_plus4  = pc_reg + 32'd4;
    assign pc_target = pc_reg + imm_ext;
    assign pc_next   = (jump || (branch && zero)) ? pc_target : pc_plus4;
    assign rf_we     = reg_write && (rd != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_reg[i] <= 32'd0;
            end
        end else if (rf_we) begin
            rf_reg[rd] <= result;
        end
    end

    assign PC        = pc_reg;
    assign DataAdr   = alu_result;
    assign WriteData = rd2;
    // Gated so a store in flight is withdrawn the moment reset asserts.
    assign MemWrite  = mem_write & reset;

endmodule

// File: tb/tb_riscv_single.sv
// Self-checking bench for riscv_single: a program in a small instruction ROM,
// with expected per-cycle PC/store activity queued and checked each cycle.
module tb_riscv_single;

    logic        clk;
    logic        reset;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];

    typedef struct {
        logic [31:0] pc;
        logic        mw;
        logic [31:0] adr;
        logic [31:0] wd;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_bad;

`ifdef RISCV_SINGLE_LUI_EN
    localparam logic [31:0] LUI_VAL = 32'h1234_5000;
`else
    localparam logic [31:0] LUI_VAL = 32'h0000_0000;
`endif

    riscv_single #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .PC        (PC),
        .Instr     (Instr),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign Instr    = imem[PC[7:2]];
    assign ReadData = dmem[DataAdr[7:2]];

    always @(posedge clk) begin
        if (MemWrite) dmem[DataAdr[7:2]] <= WriteData;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic mw,
                            input logic [31:0] adr, input logic [31:0] wd);
        exp_t e;
        e.pc  = pc;
        e.mw  = mw;
        e.adr = adr;
        e.wd  = wd;
        sb_q.push_back(e);
    endtask

    task automatic check_cycle();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        $display("txn pc=%h instr=%h mw=%b adr=%h wd=%h", PC, Instr, MemWrite, DataAdr, WriteData);
        check_val($sformatf("pc@%0h", e.pc), PC, e.pc);
        check_val($sformatf("memwrite@%0h", e.pc), {31'd0, MemWrite}, {31'd0, e.mw});
        if (e.mw) begin
            check_val($sformatf("dataadr@%0h", e.pc), DataAdr, e.adr);
            check_val($sformatf("writedata@%0h", e.pc), WriteData, e.wd);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        check_cycle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            imem[i] = 32'h0000_0013;
            dmem[i] = 32'h0;
        end
        imem[0]  = 32'h0050_0113; // addi x2,x0,5
        imem[1]  = 32'h0620_2223; // sw   x2,100(x0)
        imem[2]  = 32'h0030_0093; // addi x1,x0,3
        imem[3]  = 32'h0000_0013; // nop
        imem[4]  = 32'h0000_0463; // beq  x0,x0,8
        imem[5]  = 32'h0010_0393; // addi x7,x0,1 (skipped)
        imem[6]  = 32'h0000_8463; // beq  x1,x0,8 (not taken)
        imem[7]  = 32'h0000_0013; // nop
        imem[8]  = 32'h0080_00EF; // jal  x1,8
        imem[9]  = 32'h0010_0393; // addi x7,x0,1 (skipped)
        imem[10] = 32'h0010_2023; // sw   x1,0(x0)
        imem[11] = 32'hFFF0_0193; // addi x3,x0,-1
        imem[12] = 32'h0010_0213; // addi x4,x0,1
        imem[13] = 32'h0041_A2B3; // slt  x5,x3,x4
        imem[14] = 32'h0050_2223; // sw   x5,4(x0)
        imem[15] = 32'h0070_0013; // addi x0,x0,7
        imem[16] = 32'h0000_2423; // sw   x0,8(x0)
        imem[17] = 32'h1234_5337; // lui  x6,0x12345
        imem[18] = 32'h0060_2623; // sw   x6,12(x0)
        imem[19] = 32'h4011_0433; // sub  x8,x2,x1
        imem[20] = 32'h0080_2823; // sw   x8,16(x0)
        imem[21] = 32'h0640_2483; // lw   x9,100(x0)
        imem[22] = 32'h0104_E513; // ori  x10,x9,0x10
        imem[23] = 32'h00A0_2A23; // sw   x10,20(x0)
        imem[24] = 32'hFFFF_FFFF; // unsupported opcode
        imem[25] = 32'h0221_0133; // mul  x2,x2,x2 (unsupported funct7)
        imem[26] = 32'h0020_2C23; // sw   x2,24(x0)
        imem[27] = 32'h0F01_F593; // andi x11,x3,0xF0
        imem[28] = 32'h0001_A613; // slti x12,x3,0
        imem[29] = 32'h00C5_86B3; // add  x13,x11,x12
        imem[30] = 32'h00D0_2E23; // sw   x13,28(x0)
        imem[31] = 32'h0000_006F; // jal  x0,0

        push_exp(32'h00, 1'b0, 32'h0, 32'h0);
        push_exp(32'h04, 1'b1, 32'd100, 32'd5);
        push_exp(32'h08, 1'b0, 32'h0, 32'h0);
        push_exp(32'h0C, 1'b0, 32'h0, 32'h0);
        push_exp(32'h10, 1'b0, 32'h0, 32'h0);
        push_exp(32'h18, 1'b0, 32'h0, 32'h0);
        push_exp(32'h1C, 1'b0, 32'h0, 32'h0);
        push_exp(32'h20, 1'b0, 32'h0, 32'h0);
        push_exp(32'h28, 1'b1, 32'd0, 32'h24);
        push_exp(32'h2C, 1'b0, 32'h0, 32'h0);
        push_exp(32'h30, 1'b0, 32'h0, 32'h0);
        push_exp(32'h34, 1'b0, 32'h0, 32'h0);
        push_exp(32'h38, 1'b1, 32'd4, 32'd1);
        push_exp(32'h3C, 1'b0, 32'h0, 32'h0);
        push_exp(32'h40, 1'b1, 32'd8, 32'd0);
        push_exp(32'h44, 1'b0, 32'h0, 32'h0);
        push_exp(32'h48, 1'b1, 32'd12, LUI_VAL);
        push_exp(32'h4C, 1'b0, 32'h0, 32'h0);
        push_exp(32'h50, 1'b1, 32'd16, 32'hFFFF_FFE1);
        push_exp(32'h54, 1'b0, 32'h0, 32'h0);
        push_exp(32'h58, 1'b0, 32'h0, 32'h0);
        push_exp(32'h5C, 1'b1, 32'd20, 32'h15);
        push_exp(32'h60, 1'b0, 32'h0, 32'h0);
        push_exp(32'h64, 1'b0, 32'h0, 32'h0);
        push_exp(32'h68, 1'b1, 32'd24, 32'd5);
        push_exp(32'h6C, 1'b0, 32'h0, 32'h0);
        push_exp(32'h70, 1'b0, 32'h0, 32'h0);
        push_exp(32'h74, 1'b0, 32'h0, 32'h0);
        push_exp(32'h78, 1'b1, 32'd28, 32'hF1);
        push_exp(32'h7C, 1'b0, 32'h0, 32'h0);
        push_exp(32'h7C, 1'b0, 32'h0, 32'h0);

        // Held in reset across several edges: PC pinned, no store.
        repeat (3) @(negedge clk);
        #1;
        check_val("reset_pc", PC, 32'h0);
        check_val("reset_memwrite", {31'd0, MemWrite}, 32'd0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check_cycle();
        begin
            int n;
            n = sb_q.size();
            for (int i = 0; i < n; i++) step();
        end

        // Asynchronous reset in the middle of a cycle; registers must clear.
        #2;
        reset = 1'b0;
        #1;
        check_val("async_reset_pc", PC, 32'h0);
        check_val("async_reset_memwrite", {31'd0, MemWrite}, 32'd0);
        imem[0] = 32'h02D0_2023; // sw x13,32(x0)
        imem[1] = 32'h0220_2223; // sw x2,36(x0)
        push_exp(32'h00, 1'b1, 32'd32, 32'd0);
        push_exp(32'h04, 1'b1, 32'd36, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_cycle();
        step();

        // Reset lands while a store is being presented.
        reset = 1'b0;
        #1;
        check_val("midstore_reset_pc", PC, 32'h0);
        check_val("midstore_reset_memwrite", {31'd0, MemWrite}, 32'd0);
        @(negedge clk);
        #1;
        check_val("held_reset_pc", PC, 32'h0);
        push_exp(32'h00, 1'b1, 32'd32, 32'd0);
        push_exp(32'h04, 1'b1, 32'd36, 32'd0);
        push_exp(32'h08, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_cycle();
        step();
        step();

        check_val("scoreboard_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_single.md
RISCV_SINGLE -- requirements
Module: riscv_single

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port PC, output, 32: current instruction address, driven to the instruction memory.
REQ-005 SHALL have port Instr, input, 32: instruction at PC, returned combinationally by the instruction memory.
REQ-006 SHALL have port MemWrite, output, 1: data-memory write enable, sampled by the memory on rising clk.
REQ-007 SHALL have port DataAdr, output, 32: data-memory address, equal to the ALU result.
REQ-008 SHALL have port WriteData, output, 32: store data, equal to rs2.
REQ-009 SHALL have port ReadData, input, 32: combinational load data from the data memory.

Function
REQ-010 SHALL execute one RV32I instruction per clk cycle (single-cycle); all outputs are combinational from PC, Instr, register file and ReadData.
REQ-011 SHALL support lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq and jal.
REQ-012 SHALL decode immediates by type, sign-extended to 32 bits: I [31:20]; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; J {[31],[19:12],[20],[30:21],0}.
REQ-013 ALU ops SHALL be add, sub, and, or, and slt (signed compare, result 0 or 1); arithmetic wraps modulo 2^32; Zero = (result == 0).
REQ-014 Register file SHALL have 32x32 entries, 2 combinational read ports and 1 write port written on rising clk; x0 SHALL always read 0, and writes to x0 SHALL be discarded.
REQ-015 Next PC SHALL be PC+imm for jal, and PC+imm for beq when Zero=1; otherwise PC+4.
REQ-016 Write-back source SHALL be the ALU result for R/I-ALU ops, ReadData for lw, and PC+4 for jal.
REQ-017 MemWrite SHALL be 1 only for sw.
REQ-018 Unsupported opcode/funct combinations SHALL write no register, keep MemWrite at 0, and advance PC by 4.
REQ-019 A read of a register written in the same cycle SHALL return the old value.

Reset
REQ-020 While reset=0: PC=RESET_PC, all registers x1..x31 = 0, MemWrite=0.
REQ-021 Reset assertion mid-instruction SHALL take effect immediately (asynchronously), with no register write at the following edge.
REQ-022 The first instruction after reset deassertion SHALL be fetched at RESET_PC.

Configuration
REQ-023 Macro RISCV_SINGLE_LUI_EN: when defined, lui (opcode 0110111) SHALL write {Instr[31:12],12'h000} to rd; when undefined, lui SHALL be treated as unsupported per REQ-018.

Structure
REQ-024 Package riscv_single_pkg SHALL hold the opcode constants, ALU-control encodings, immediate-type encodings and the result-source encodings.
REQ-025 Decode logic SHALL be a sub-module riscv_single_decoder (Instr in; RegWrite, ImmSrc, ALUSrc, ALUControl, MemWrite, ResultSrc, Branch, Jump out); the datapath stays in riscv_single.

Verification
REQ-026 Hold reset=0, then release -> PC=0 during reset and MemWrite=0; PC=4 after the first rising edge.
REQ-027 Instr 0x00500113 (addi x2,x0,5) then 0x06202223 (sw x2,100(x0)) -> during sw: DataAdr=100, WriteData=5, MemWrite=1.
REQ-028 Instr 0x00000463 (beq x0,x0,8) at PC=0x10 -> next PC=0x18; with x1≠x0 instead, next PC=0x14.
REQ-029 Instr 0x008000EF (jal x1,8) at PC=0x20 -> next PC=0x28; a following sw of x1 shows WriteData=0x24.
REQ-030 x3=-1, x4=1, slt x5,x3,x4, then sw x5 -> WriteData=1; addi x0,x0,7, then sw x0 -> WriteData=0.
REQ-031 Instr lui x6,0x12345 then sw x6 -> WriteData=0x12345000 with RISCV_SINGLE_LUI_EN defined; x6 stays 0 with it undefined.
